// File: rtl/dco_therm_stepper.sv
// ============================================================================
// dco_therm_stepper : ramps a thermometer-coded DCO bank toward a binary
//                     target, one element per step, at a fixed step period.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dco_therm_stepper #(
  parameter int WIDTH = 6,
  parameter int DIV   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  input  logic [$clog2(WIDTH+1)-1:0]   req_code,
  output logic                         req_ready,
  output logic [WIDTH-1:0]             therm,
  output logic                         busy,
  output logic                         done,
  output logic                         all_off
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_STEP = 2'd2
  } state_t;

  localparam logic [CW-1:0] LVL_MAX    = CW'(WIDTH);
  localparam logic [7:0]    CNT_RELOAD = 8'(DIV - 1);
  // With DIV==1 the wait phase has zero length, so arming lands directly in STEP.
  localparam state_t        S_ARM      = (DIV == 1) ? S_STEP : S_WAIT;

  state_t           state_q;
  logic [7:0]       cnt_q;
  logic [CW-1:0]    lvl_q;
  logic [CW-1:0]    tgt_q;
  logic [WIDTH-1:0] therm_q;
  logic             busy_q;
  logic             done_q;
  logic             all_off_q;

  logic [CW-1:0]    tgt_d;
  logic             step_up;
  logic [CW-1:0]    lvl_d;
  logic [WIDTH-1:0] therm_d;

  assign tgt_d   = (req_code > LVL_MAX) ? LVL_MAX : req_code;
  assign step_up = (tgt_q > lvl_q);
  assign lvl_d   = step_up ? (lvl_q + CW'(1)) : (lvl_q - CW'(1));
  assign therm_d = step_up ? {therm_q[WIDTH-2:0], 1'b1} : (therm_q >> 1);

  // The STEP cycle is the last cycle of each DIV-cycle period, so step j
  // lands exactly j*DIV edges after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      lvl_q     <= '0;
      tgt_q     <= '0;
      therm_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      all_off_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            tgt_q <= tgt_d;
            if (tgt_d == lvl_q) begin
              done_q <= 1'b1;
            end else begin
              state_q <= S_ARM;
              cnt_q   <= CNT_RELOAD;
              busy_q  <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q <= 8'd1) begin
            state_q <= S_STEP;
          end
        end
        S_STEP: begin
          therm_q   <= therm_d;
          lvl_q     <= lvl_d;
          all_off_q <= (therm_d == '0);
          if (lvl_d == tgt_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_ARM;
            cnt_q   <= CNT_RELOAD;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign therm     = therm_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign all_off   = all_off_q;

endmodule

`default_nettype wire

// File: tb/tb_dco_therm_stepper.sv
// ============================================================================
// tb_dco_therm_stepper : directed table-driven bench for dco_therm_stepper.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dco_therm_stepper;

  localparam int WIDTH = 6;
  localparam int DIV   = 4;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0;
  logic [CW-1:0]    req_code = '0;
  logic             req_ready;
  logic [WIDTH-1:0] therm;
  logic             busy;
  logic             done;
  logic             all_off;

  int n_cmp  = 0;
  int n_fail = 0;
  int ml     = 0;

  always #5 clk = ~clk;

  dco_therm_stepper #(.WIDTH(WIDTH), .DIV(DIV)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_code  (req_code),
    .req_ready (req_ready),
    .therm     (therm),
    .busy      (busy),
    .done      (done),
    .all_off   (all_off)
  );

  typedef struct {
    logic [CW-1:0]    code;
    logic [WIDTH-1:0] exp_therm;
    int               exp_k;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [WIDTH-1:0] th(input int l);
    th = WIDTH'((1 << l) - 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_req(input logic [CW-1:0] code, input logic [WIDTH-1:0] exp_final,
                         input int k);
    int dir;
    dir = ($countones(exp_final) > ml) ? 1 : -1;
    req_valid = 1'b1;
    req_code  = code;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (k == 0) begin
      chk("eq_done",  done, 1);
      chk("eq_busy",  busy, 0);
      chk("eq_ready", req_ready, 1);
      chk("eq_therm", therm, exp_final);
    end else begin
      chk("acc_busy",  busy, 1);
      chk("acc_ready", req_ready, 0);
      chk("acc_done",  done, 0);
      for (int j = 1; j <= k; j++) begin
        for (int c = 1; c < DIV; c++) begin
          @(posedge clk); #1;
          chk("wait_therm", therm, th(ml));
          chk("wait_busy",  busy, 1);
        end
        @(posedge clk); #1;
        ml = ml + dir;
        chk("step_therm",   therm, th(ml));
        chk("step_onebit",  $countones(therm ^ th(ml - dir)), 1);
        chk("step_alloff",  all_off, (ml == 0));
        if (j == k) begin
          chk("final_therm", therm, exp_final);
          chk("final_done",  done, 1);
          chk("final_busy",  busy, 0);
          chk("final_ready", req_ready, 1);
        end else begin
          chk("mid_done", done, 0);
          chk("mid_busy", busy, 1);
        end
      end
    end
  endtask

  initial begin
    vecs[0] = '{3'd6, 6'b111111, 6};
    vecs[1] = '{3'd2, 6'b000011, 4};
    vecs[2] = '{3'd3, 6'b000111, 1};
    vecs[3] = '{3'd3, 6'b000111, 0};
    vecs[4] = '{3'd0, 6'b000000, 3};
    vecs[5] = '{3'd7, 6'b111111, 6};
    vecs[6] = '{3'd6, 6'b111111, 0};

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_therm",  therm, 0);
    chk("rst_alloff", all_off, 1);
    chk("rst_busy",   busy, 0);
    chk("rst_done",   done, 0);
    chk("rst_ready",  req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    ml  = 0;

    for (int i = 0; i < 7; i++) begin
      run_req(vecs[i].code, vecs[i].exp_therm, vecs[i].exp_k);
    end

    // Request held during busy must be ignored and not queued
    @(posedge clk); #1;
    chk("idle_done_fell", done, 0);
    req_valid = 1'b1;
    req_code  = 3'd5;
    @(posedge clk); #1;
    chk("ign_acc_busy", busy, 1);
    req_code = 3'd0;
    for (int c = 1; c < DIV; c++) begin
      @(posedge clk); #1;
      chk("ign_ready", req_ready, 0);
      chk("ign_therm", therm, 6'b111111);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("ign_step_therm", therm, 6'b011111);
    chk("ign_step_done",  done, 1);
    ml = 5;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("ign_hold_therm", therm, 6'b011111);
      chk("ign_hold_busy",  busy, 0);
      chk("ign_hold_done",  done, 0);
    end

    // Reset mid-ramp at level 3
    req_valid = 1'b1;
    req_code  = 3'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2 * DIV) @(posedge clk);
    #1;
    chk("mr_level3", therm, 6'b000111);
    chk("mr_busy",   busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_therm",  therm, 0);
    chk("mr_alloff", all_off, 1);
    chk("mr_busy0",  busy, 0);
    chk("mr_done0",  done, 0);
    chk("mr_ready",  req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    ml  = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("mr_no_done", done, 0);
      chk("mr_still0",  therm, 0);
    end
    run_req(3'd1, 6'b000001, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dco_therm_stepper.md
# dco_therm_stepper

Sequential driver for the thermometer-coded DCO capacitor bank of the ADPLL. It accepts a binary target level over a valid/ready handshake and walks a WIDTH-bit thermometer word toward that level one bit per step, at a programmable step rate, so no step ever switches more than one bank element. It is the expanding counterpart of the bank's wide NOR idle detect: it drives the WIDTH enable lines that the detect reduces, and it exports its own registered all-off flag.

## Interface

Parameters:
- WIDTH, 6, number of thermometer bank elements; legal range 2..15.
- DIV, 4, clock cycles between consecutive steps; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  1  target request valid.
- req_code  input  CW=clog2(WIDTH+1)  binary target level, 0..WIDTH; values above WIDTH are clamped to WIDTH.
- req_ready  output  1  high when a request can be accepted; equals (state==IDLE).
- therm  output  WIDTH  registered thermometer word; bit i set means element i enabled; always of the form 0…01…1.
- busy  output  1  registered; high in WAIT and STEP.
- done  output  1  registered one-cycle pulse at the end of every accepted request.
- all_off  output  1  registered; high exactly when therm==0.

## Operation

- Reset values: therm=0, all_off=1, busy=0, done=0, state=IDLE (req_ready=1), step counter=0, target register=0.
- The current level L is the number of set bits in therm. It is held in a CW-bit register that is kept consistent with therm.
- Handshake: a request is accepted on a rising edge with req_valid & req_ready. req_code is sampled only at acceptance and clamped to T=min(req_code, WIDTH). req_valid with req_ready=0 is ignored and is not queued.
- State IDLE:
  - Acceptance with T==L: stay IDLE and pulse done on the next cycle; therm is unchanged.
  - Acceptance with T!=L: go to WAIT, load the counter with DIV-1, set busy=1.
- State WAIT: decrement the counter each cycle. When the counter is 0, go to STEP on that edge.
- State STEP (the step is applied on the edge leaving STEP):
  - Up (T>L): therm becomes {therm[WIDTH-2:0],1'b1}. The lowest zero bit is set.
  - Down (T<L): therm becomes therm>>1. The highest one bit is cleared.
  - If the new L equals T: go to IDLE, busy=0, done=1 for one cycle.
  - Otherwise: reload the counter with DIV-1 and go back to WAIT.
- With DIV=1, WAIT is zero-length: the counter is already 0, so a step is applied every edge.
- Each step has these properties:
  - Exactly one therm bit toggles.
  - L never overshoots T.
  - all_off is updated on the same edge as therm.

## Timing

- Let the acceptance edge be E0 and k=|T−L|. Step j is applied at edge E0+j·DIV for j=1..k.
- The last step, state return to IDLE, busy fall and done rise all occur on edge E0+k·DIV. done falls on the next edge.
- When T==L, done is high for the cycle following E0 and busy stays 0.
- req_ready is high during the done cycle. A request presented then is accepted at the following edge, so back-to-back requests need no idle gap.
- Reset asserted at any time, including mid-ramp, forces all outputs to their reset values immediately, without waiting for clk. The in-flight request is discarded and no done pulse is produced. The first acceptance is possible on the first rising edge after rst deasserts.

## Test plan

- Reset: assert rst mid-cycle → therm=000000, all_off=1, busy=0, done=0, req_ready=1 with no clock edge required.
- Ramp up, DIV=4, from 0 with req_code=6 accepted at E0 → therm=000001 at E0+4, 000011 at E0+8, …, 111111 at E0+24. done is high for exactly the cycle after E0+24. all_off falls at E0+4.
- Ramp down, DIV=4, from 111111 with req_code=2 → 011111, 001111, 000111, 000011 at E0+4, +8, +12, +16. done follows the last step. Check that exactly one bit toggles per step.
- Equal and clamp cases:
  - req_code equal to the current level 3 → done pulse on the next cycle, busy stays 0, therm unchanged.
  - req_code=7 with WIDTH=6 from 0 → ramps to 111111.
- Handshake: req_valid held during busy → ignored; req_ready=0. A new request presented in the done cycle → accepted on the next edge and its ramp starts with no gap.
- Reset mid-ramp at level 3 → therm=0 immediately, no done pulse. After release, req_code=1 → therm=000001 at E0+DIV.
